// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one request/response fetch per
// fetch_req, latches the returned word into the IR and applies PC redirects.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no fetch outstanding; accepts fetch_req and direct pc_load
// S_REQ  | imem_req asserted at pc_q, waiting for imem_gnt
// S_WAIT | request granted, waiting for imem_rvalid
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_req_i,
   input  logic        pc_load_i,
   input  logic [31:0] pc_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] ir_o,
   output logic [6:0]  opcode_o,
   output logic [31:0] pc_out_o,
   output logic [31:0] pc_plus4_o,
   output logic        ir_valid_o,
   output logic        busy_o,
   output logic        misaligned_err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        ir_valid_q, ir_valid_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_addr_q, redir_addr_d;
   logic        mis_err_q, mis_err_d;
   logic [31:0] target_al;

   assign target_al = {pc_target_i[31:2], 2'b00};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         ir_q         <= NOP_INSTR;
         pc_out_q     <= RESET_PC;
         ir_valid_q   <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_addr_q <= RESET_PC;
         mis_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         pc_out_q     <= pc_out_d;
         ir_valid_q   <= ir_valid_d;
         redir_pend_q <= redir_pend_d;
         redir_addr_q <= redir_addr_d;
         mis_err_q    <= mis_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      pc_out_d     = pc_out_q;
      ir_valid_d   = ir_valid_q;
      redir_pend_d = redir_pend_q;
      redir_addr_d = redir_addr_q;
      mis_err_d    = mis_err_q;

      if (pc_load_i && (pc_target_i[1:0] != 2'b00)) mis_err_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (pc_load_i) pc_d = target_al;
            if (fetch_req_i) begin
               state_d    = S_REQ;
               ir_valid_d = 1'b0;
            end
         end
         S_REQ: begin
            if (pc_load_i) begin
               redir_pend_d = 1'b1;
               redir_addr_d = target_al;
            end
            if (imem_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (pc_load_i) begin
               redir_pend_d = 1'b1;
               redir_addr_d = target_al;
            end
            if (imem_rvalid_i) begin
               state_d      = S_IDLE;
               ir_d         = imem_rdata_i;
               pc_out_d     = pc_q;
               ir_valid_d   = 1'b1;
               redir_pend_d = 1'b0;
               // A redirect arriving on the response cycle is the newest one and wins.
               if (pc_load_i)         pc_d = target_al;
               else if (redir_pend_q) pc_d = redir_addr_q;
               else                   pc_d = pc_q + 32'd4;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_o       = (state_q == S_REQ);
   assign imem_addr_o      = pc_q;
   assign busy_o           = (state_q != S_IDLE);
   assign ir_o             = ir_q;
   assign opcode_o         = ir_q[6:0];
   assign pc_out_o         = pc_out_q;
   assign pc_plus4_o       = pc_out_q + 32'd4;
   assign ir_valid_o       = ir_valid_q;
   assign misaligned_err_o = mis_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch
// transactions checked against a transaction-level reference model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, pc_load, gnt, rvalid;
   logic [31:0] pc_target, rdata;
   logic        imem_req, ir_valid, busy, mis_err;
   logic [31:0] imem_addr, ir, pc_out, pc_plus4;
   logic [6:0]  opcode;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc, m_ir, m_pc_out, m_redir;
   logic        m_valid, m_pend, m_err;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk_i(clk), .rst_i(rst), .fetch_req_i(fetch_req), .pc_load_i(pc_load),
      .pc_target_i(pc_target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .ir_o(ir), .opcode_o(opcode), .pc_out_o(pc_out), .pc_plus4_o(pc_plus4),
      .ir_valid_o(ir_valid), .busy_o(busy), .misaligned_err_o(mis_err)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] rand_tgt();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) r[31:4] = 28'hFFF_FFFF;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      fetch_req = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
   endtask

   // stimulus only: one fetch with immediate grant and response
   task automatic complete_fetch(input logic [31:0] data);
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = data; tick(); rvalid = 1'b0;
   endtask

   task automatic test_reset();
      quiet();
      rst = 1'b1;
      tick(); tick();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_imem_req got %b exp 0", imem_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (ir !== NOP_INSTR) begin n_err++; $display("FAIL rst_ir got %h exp %h", ir, NOP_INSTR); end
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid got %b exp 0", ir_valid); end
      n_cmp++; if (pc_out !== RESET_PC) begin n_err++; $display("FAIL rst_pc_out got %h exp %h", pc_out, RESET_PC); end
      n_cmp++; if (pc_plus4 !== RESET_PC + 32'd4) begin n_err++; $display("FAIL rst_pc_plus4 got %h exp %h", pc_plus4, RESET_PC + 32'd4); end
      n_cmp++; if (mis_err !== 1'b0) begin n_err++; $display("FAIL rst_mis_err got %b exp 0", mis_err); end
      n_cmp++; if (opcode !== NOP_INSTR[6:0]) begin n_err++; $display("FAIL rst_opcode got %b exp %b", opcode, NOP_INSTR[6:0]); end
      rst = 1'b0;
      tick();
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_addr got %h exp %h", imem_addr, RESET_PC); end
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b exp 1", imem_req); end
      // asynchronous reset: asserted mid-cycle, visible before any clock edge
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_rst_req got %b exp 0", imem_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy got %b exp 0", busy); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_req got %b exp 1", busy); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_wait got req=%b busy=%b exp req=0 busy=1", imem_req, busy); end
      rvalid = 1'b1; rdata = 32'h0050_0093; tick(); rvalid = 1'b0;
      n_cmp++; if (ir !== 32'h0050_0093) begin n_err++; $display("FAIL basic_ir got %h exp 00500093", ir); end
      n_cmp++; if (opcode !== 7'b0010011) begin n_err++; $display("FAIL basic_opcode got %b exp 0010011", opcode); end
      n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL basic_pc_out got %h exp 0", pc_out); end
      n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL basic_pc_plus4 got %h exp 4", pc_plus4); end
      n_cmp++; if (ir_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done got valid=%b busy=%b exp 1 0", ir_valid, busy); end
   endtask

   task automatic test_gnt_stall();
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid_clr got %b exp 0", ir_valid); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h4 || busy !== 1'b1 || ir !== 32'h0050_0093) begin
            n_err++;
            $display("FAIL stall_%0d got req=%b addr=%h busy=%b ir=%h exp 1 00000004 1 00500093", i, imem_req, imem_addr, busy, ir);
         end
         if (i < 3) tick();
      end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h00A0_0113; tick(); rvalid = 1'b0;
      n_cmp++; if (ir !== 32'h00A0_0113 || pc_out !== 32'h4) begin n_err++; $display("FAIL stall_done got ir=%h pc_out=%h exp 00a00113 00000004", ir, pc_out); end
   endtask

   task automatic test_redirect_wait();
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      pc_load = 1'b1; pc_target = 32'h40; tick(); pc_load = 1'b0;
      n_cmp++; if (busy !== 1'b1 || ir_valid !== 1'b0) begin n_err++; $display("FAIL redir_wait got busy=%b valid=%b exp 1 0", busy, ir_valid); end
      rvalid = 1'b1; rdata = mem_word(32'h8); tick(); rvalid = 1'b0;
      n_cmp++; if (ir !== mem_word(32'h8)) begin n_err++; $display("FAIL redir_ir got %h exp %h", ir, mem_word(32'h8)); end
      n_cmp++; if (pc_out !== 32'h8) begin n_err++; $display("FAIL redir_pc_out got %h exp 8", pc_out); end
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_next_addr got %h exp 40", imem_addr); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = mem_word(32'h40); tick(); rvalid = 1'b0;
   endtask

   task automatic test_misaligned();
      pc_load = 1'b1; pc_target = 32'h43; tick(); pc_load = 1'b0;
      n_cmp++; if (mis_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %b exp 1", mis_err); end
      n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid_kept got %b exp 1", ir_valid); end
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_addr got %h exp 40", imem_addr); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = mem_word(32'h40); tick(); rvalid = 1'b0;
      complete_fetch(mem_word(32'h44));
      n_cmp++; if (pc_out !== 32'h44 || mis_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got pc_out=%h err=%b exp 44 1", pc_out, mis_err); end
   endtask

   task automatic test_wrap();
      pc_load = 1'b1; pc_target = 32'hFFFF_FFFC; tick(); pc_load = 1'b0;
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h1234_5037; tick(); rvalid = 1'b0;
      n_cmp++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc got pc_out=%h plus4=%h exp fffffffc 0", pc_out, pc_plus4); end
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h0000_0013; tick(); rvalid = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
      tick();
      rst = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; tick(); rvalid = 1'b0;
      n_cmp++; if (ir !== NOP_INSTR || ir_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ir got ir=%h valid=%b exp %h 0", ir, ir_valid, NOP_INSTR); end
      n_cmp++; if (busy !== 1'b0 || mis_err !== 1'b0) begin n_err++; $display("FAIL midrst_state got busy=%b err=%b exp 0 0", busy, mis_err); end
      fetch_req = 1'b1; tick(); fetch_req = 1'b0;
      n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL midrst_addr got %h exp %h", imem_addr, RESET_PC); end
      gnt = 1'b1; tick(); gnt = 1'b0;
      rvalid = 1'b1; rdata = mem_word(RESET_PC); tick(); rvalid = 1'b0;
   endtask

   // Transaction-level model: a fetch reads the current PC; the next PC is the
   // most recent redirect seen during the fetch, otherwise PC+4.
   task automatic test_random();
      logic [31:0] tgt;
      int gd, rd, gap;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      m_pc = RESET_PC; m_ir = NOP_INSTR; m_pc_out = RESET_PC;
      m_valid = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_redir = 32'h0;
      for (int t = 0; t < 60; t++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
            pc_load = ($urandom_range(0, 2) == 0); tgt = rand_tgt(); pc_target = tgt;
            if (pc_load) begin m_pc = {tgt[31:2], 2'b00}; m_err |= (tgt[1:0] != 2'b00); end
            tick();
            n_cmp++;
            if (busy !== 1'b0 || ir !== m_ir || ir_valid !== m_valid || mis_err !== m_err) begin
               n_err++;
               $display("FAIL rnd_idle t=%0d got busy=%b ir=%h v=%b err=%b exp 0 %h %b %b", t, busy, ir, ir_valid, mis_err, m_ir, m_valid, m_err);
            end
         end
         quiet();
         fetch_req = 1'b1;
         pc_load = ($urandom_range(0, 3) == 0); tgt = rand_tgt(); pc_target = tgt;
         if (pc_load) begin m_pc = {tgt[31:2], 2'b00}; m_err |= (tgt[1:0] != 2'b00); end
         m_valid = 1'b0;
         tick();
         fetch_req = 1'b0;
         gd = $urandom_range(0, 3);
         for (int k = 0; k <= gd; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || busy !== 1'b1 || ir_valid !== 1'b0) begin
               n_err++;
               $display("FAIL rnd_req t=%0d got req=%b addr=%h busy=%b v=%b exp 1 %h 1 0", t, imem_req, imem_addr, busy, ir_valid, m_pc);
            end
            gnt = (k == gd); rvalid = 1'($urandom); rdata = $urandom;
            pc_load = ($urandom_range(0, 3) == 0); tgt = rand_tgt(); pc_target = tgt;
            if (pc_load) begin m_pend = 1'b1; m_redir = {tgt[31:2], 2'b00}; m_err |= (tgt[1:0] != 2'b00); end
            tick();
         end
         rd = $urandom_range(0, 3);
         for (int k = 0; k <= rd; k++) begin
            n_cmp++;
            if (imem_req !== 1'b0 || busy !== 1'b1) begin
               n_err++;
               $display("FAIL rnd_wait t=%0d got req=%b busy=%b exp 0 1", t, imem_req, busy);
            end
            rvalid = (k == rd); rdata = mem_word(m_pc);
            gnt = 1'($urandom); fetch_req = 1'($urandom);
            pc_load = ($urandom_range(0, 3) == 0); tgt = rand_tgt(); pc_target = tgt;
            if (pc_load) m_err |= (tgt[1:0] != 2'b00);
            tick();
            if (k == rd) begin
               m_ir = mem_word(m_pc); m_pc_out = m_pc; m_valid = 1'b1;
               if (pc_load)     m_pc = {tgt[31:2], 2'b00};
               else if (m_pend) m_pc = m_redir;
               else             m_pc = m_pc + 32'd4;
               m_pend = 1'b0;
            end else if (pc_load) begin
               m_pend = 1'b1; m_redir = {tgt[31:2], 2'b00};
            end
         end
         quiet();
         n_cmp++;
         if (ir !== m_ir || opcode !== m_ir[6:0] || pc_out !== m_pc_out || pc_plus4 !== m_pc_out + 32'd4) begin
            n_err++;
            $display("FAIL rnd_resp t=%0d got ir=%h op=%b pc_out=%h p4=%h exp %h %b %h %h", t, ir, opcode, pc_out, pc_plus4, m_ir, m_ir[6:0], m_pc_out, m_pc_out + 32'd4);
         end
         n_cmp++;
         if (ir_valid !== 1'b1 || busy !== 1'b0 || mis_err !== m_err) begin
            n_err++;
            $display("FAIL rnd_flags t=%0d got v=%b busy=%b err=%b exp 1 0 %b", t, ir_valid, busy, mis_err, m_err);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      quiet();
      test_reset();
      test_basic();
      test_gnt_stall();
      test_redirect_wait();
      test_misaligned();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
